// File: rtl/sbox_sched.sv
// Time-shared AES S-box scheduler: one 32-bit column of four S-boxes serves
// both a 128-bit state SubBytes requester and a 32-bit key-schedule SubWord requester.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the AES affine transform
  function automatic logic [7:0] sub_byte(input logic [7:0] v);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = v;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign y = sub_byte(a);
endmodule

module sbox_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_ack,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_ack,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic         busy
);
  localparam int unsigned ST_W  = 128;
  localparam int unsigned COL_W = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WORD  = 2'd1;
  localparam logic [1:0] STATE = 2'd2;

  localparam logic LG_ST = 1'b0;
  localparam logic LG_KW = 1'b1;

  logic [1:0]      state_q, state_d;
  logic [1:0]      beat_q;
  logic            last_q;
  logic            gnt_kw, gnt_st;
  logic [ST_W-1:0] op_q;
  logic [ST_W-1:0] buf_q;
  logic [COL_W-1:0] col, sub;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and arbitration: kw wins unless it won last time and st is waiting
  always_comb begin
    state_d = state_q;
    gnt_kw  = 1'b0;
    gnt_st  = 1'b0;
    case (state_q)
      IDLE: begin
        if (kw_req && !(last_q == LG_KW && st_req)) begin
          gnt_kw  = 1'b1;
          state_d = WORD;
        end else if (st_req) begin
          gnt_st  = 1'b1;
          state_d = STATE;
        end
      end
      WORD:    state_d = IDLE;
      STATE:   if (beat_q == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A captured word sits in column 0 so both requesters share one column mux
  always_comb begin
    case (beat_q)
      2'd0:    col = op_q[127:96];
      2'd1:    col = op_q[95:64];
      2'd2:    col = op_q[63:32];
      default: col = op_q[31:0];
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(col[8*g +: 8]), .y(sub[8*g +: 8]));
  end

  // Operand capture, beat sequencing and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= 2'd0;
      last_q  <= LG_ST;
      op_q    <= '0;
      buf_q   <= '0;
      st_ack  <= 1'b0;
      st_done <= 1'b0;
      st_out  <= '0;
      kw_ack  <= 1'b0;
      kw_done <= 1'b0;
      kw_out  <= '0;
      busy    <= 1'b0;
    end else begin
      busy    <= (state_d != IDLE);
      kw_ack  <= gnt_kw;
      st_ack  <= gnt_st;
      kw_done <= 1'b0;
      st_done <= 1'b0;
      if (gnt_kw) begin
        op_q[127:96] <= kw_in;
        last_q       <= LG_KW;
      end
      if (gnt_st) begin
        op_q   <= st_in;
        last_q <= LG_ST;
      end
      if (state_q == WORD) begin
        kw_out  <= sub;
        kw_done <= 1'b1;
      end
      if (state_q == STATE) begin
        case (beat_q)
          2'd0:    buf_q[127:96] <= sub;
          2'd1:    buf_q[95:64]  <= sub;
          2'd2:    buf_q[63:32]  <= sub;
          default: buf_q[31:0]   <= sub;
        endcase
        beat_q <= beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          st_out  <= {buf_q[127:32], sub};
          st_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sbox_sched.sv
// Directed bench for sbox_sched: reset, fairness, word/state substitution,
// mid-operation abort and operand stability.

module tb_sbox_sched;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_req, kw_req;
  logic [127:0] st_in;
  logic [31:0]  kw_in;
  logic         st_ack, st_done, kw_ack, kw_done, busy;
  logic [127:0] st_out;
  logic [31:0]  kw_out;

  int nchk  = 0;
  int npass = 0;
  int ev[$];
  int ev_exp[9] = '{1*8+1, 2*8+2, 3*8+3, 7*8+4, 8*8+1, 9*8+2, 10*8+3, 14*8+4, 15*8+1};

  sbox_sched dut (
    .clk(clk), .rst_n(rst_n),
    .st_req(st_req), .st_in(st_in), .st_ack(st_ack), .st_done(st_done), .st_out(st_out),
    .kw_req(kw_req), .kw_in(kw_in), .kw_ack(kw_ack), .kw_done(kw_done), .kw_out(kw_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic run_kw(input logic [31:0] v, input logic [31:0] exp);
    int n;
    kw_in  = v;
    kw_req = 1'b1;
    n = 1;
    @(negedge clk);
    while (!kw_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("kw_ack", kw_ack, 1'b1);
    chk("kw_busy", busy, 1'b1);
    kw_req = 1'b0;
    kw_in  = $urandom;
    @(negedge clk);
    chk("kw_done", kw_done, 1'b1);
    chk("kw_out", kw_out, exp);
    chk("kw_no_st_done", st_done, 1'b0);
    @(negedge clk);
    chk("kw_done_pulse", kw_done, 1'b0);
    chk("kw_out_held", kw_out, exp);
  endtask

  task automatic run_st(input logic [127:0] v, input logic [127:0] exp);
    int n;
    st_in  = v;
    st_req = 1'b1;
    n = 1;
    @(negedge clk);
    while (!st_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("st_ack", st_ack, 1'b1);
    st_req = 1'b0;
    st_in  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_done_early", st_done, 1'b0);
    end
    @(negedge clk);
    chk("st_done", st_done, 1'b1);
    chk("st_out", st_out, exp);
    chk("st_no_kw_done", kw_done, 1'b0);
    @(negedge clk);
    chk("st_done_pulse", st_done, 1'b0);
    chk("st_idle", busy, 1'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    st_req = 1'b1;
    kw_req = 1'b1;
    kw_in  = 32'h00010253;
    st_in  = 128'h0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {kw_ack, st_ack, kw_done, st_done, busy}, 5'b0);
    chk("rst_st_out", st_out, 128'h0);
    chk("rst_kw_out", kw_out, 32'h0);

    // Both requests held from reset: grants alternate starting with kw
    rst_n = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (kw_ack)  ev.push_back(n*8+1);
      if (kw_done) ev.push_back(n*8+2);
      if (st_ack)  ev.push_back(n*8+3);
      if (st_done) ev.push_back(n*8+4);
    end
    chk("fair_count", ev.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("fair_ev%0d", i), (i < ev.size()) ? ev[i] : -1, ev_exp[i]);
    chk("fair_st_out", st_out, {16{8'h63}});
    kw_req = 1'b0;
    st_req = 1'b0;
    @(negedge clk);
    chk("fair_kw_out", kw_out, 32'h637c77ed);
    repeat (2) @(negedge clk);

    run_kw(32'h00010253, 32'h637c77ed);
    run_kw(32'hffff5301, 32'h1616ed7c);
    run_st(128'h0, {16{8'h63}});
    run_st({16{8'hff}}, {16{8'h16}});
    run_st(128'h00010253_ffffffff_53535353_01020000,
           128'h637c77ed_16161616_edededed_7c776363);

    // Reset during beat 2 of a state operation aborts it silently
    st_in  = {16{8'h01}};
    st_req = 1'b1;
    @(negedge clk);
    chk("abort_ack", st_ack, 1'b1);
    st_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_st_out", st_out, 128'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", st_done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done_after", st_done, 1'b0);
    run_st({16{8'h53}}, {16{8'hed}});

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
